// File: rtl/mini_alu_pkg.sv
// Shared opcode encoding and word-size constants for the mini-SRC ALU.
// The optional divider is enabled by defining MINI_ALU_DIV_EN.
package mini_alu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [4:0] {
    OP_ADD   = 5'b00000,
    OP_SUB   = 5'b00001,
    OP_AND   = 5'b00010,
    OP_OR    = 5'b00011,
    OP_SHR   = 5'b00100,
    OP_SHRA  = 5'b00101,
    OP_SHL   = 5'b00110,
    OP_ROR   = 5'b00111,
    OP_ROL   = 5'b01000,
    OP_MUL   = 5'b01001,
    OP_DIV   = 5'b01010,
    OP_NEG   = 5'b01011,
    OP_NOT   = 5'b01100,
    OP_PASSA = 5'b01101,
    OP_PASSB = 5'b01110
  } alu_op_e;

  localparam logic [2*WORD_W-1:0] RESULT_RESERVED = 64'h0;

endpackage

// File: rtl/mini_alu_divider.sv
// Combinational signed divider: quotient truncates toward zero, remainder follows
// the dividend's sign; divide-by-zero and the most-negative/-1 overflow are pinned.
module mini_alu_divider
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a_s;
  logic             neg_b_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH:0]   part_rem_s;
  logic [WIDTH-1:0] quo_mag_s;
  logic [WIDTH-1:0] rem_mag_s;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
  always_comb begin
    neg_a_s = dividend[WIDTH-1];
    neg_b_s = divisor[WIDTH-1];
    if (neg_a_s) begin
      mag_a_s = -dividend;
    end else begin
      mag_a_s = dividend;
    end
    if (neg_b_s) begin
      mag_b_s = -divisor;
    end else begin
      mag_b_s = divisor;
    end
  end

  // Restoring division on magnitudes, one quotient bit per unrolled step
  always_comb begin
    part_rem_s = '0;
    quo_mag_s  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      part_rem_s = {part_rem_s[WIDTH-1:0], mag_a_s[i]};
      if (part_rem_s >= {1'b0, mag_b_s}) begin
        part_rem_s   = part_rem_s - {1'b0, mag_b_s};
        quo_mag_s[i] = 1'b1;
      end else begin
        quo_mag_s[i] = 1'b0;
      end
    end
    rem_mag_s = part_rem_s[WIDTH-1:0];
  end

  // Sign restoration plus the two pinned corner cases
  always_comb begin
    if (divisor == '0) begin
      quotient  = '1;
      remainder = dividend;
    end else if ((dividend == MOST_NEG) && (divisor == '1)) begin
      quotient  = MOST_NEG;
      remainder = '0;
    end else begin
      if (neg_a_s ^ neg_b_s) begin
        quotient = -quo_mag_s;
      end else begin
        quotient = quo_mag_s;
      end
      if (neg_a_s) begin
        remainder = -rem_mag_s;
      end else begin
        remainder = rem_mag_s;
      end
    end
  end

endmodule

// File: rtl/mini_alu.sv
// mini-SRC ALU: one combinational operation selected by Control, captured in reg_C.
// Define MINI_ALU_DIV_EN to build the signed divider; otherwise DIV is reserved.
module mini_alu
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic [4:0]         Control,
  input  logic [WIDTH-1:0]   reg_A,
  input  logic [WIDTH-1:0]   reg_B,
  output logic [2*WIDTH-1:0] reg_C
);

  localparam int SHAMT_W = $clog2(WIDTH);

  function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

  logic [SHAMT_W-1:0] amt_s;
  logic [WIDTH-1:0]   sra_s;
  logic [2*WIDTH-1:0] dbl_s;
  logic [2*WIDTH-1:0] ror_full_s;
  logic [2*WIDTH-1:0] rol_full_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] result_s;

`ifdef MINI_ALU_DIV_EN
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;

  mini_alu_divider #(
    .WIDTH     (WIDTH)
  ) u_divider (
    .dividend  (reg_A),
    .divisor   (reg_B),
    .quotient  (quo_s),
    .remainder (rem_s)
  );
`endif

  // Shared shift/rotate/multiply terms; rotates read a window of A concatenated with itself
  always_comb begin
    amt_s      = reg_B[SHAMT_W-1:0];
    sra_s      = $signed(reg_A) >>> amt_s;
    dbl_s      = {reg_A, reg_A};
    ror_full_s = dbl_s >> amt_s;
    rol_full_s = dbl_s << amt_s;
    prod_s     = $signed({{WIDTH{reg_A[WIDTH-1]}}, reg_A})
               * $signed({{WIDTH{reg_B[WIDTH-1]}}, reg_B});
  end

  // Operation select; single-word results are zero-extended into the high half
  always_comb begin
    result_s = (2*WIDTH)'(RESULT_RESERVED);
    case (Control)
      OP_ADD:   result_s = zext(reg_A + reg_B);
      OP_SUB:   result_s = zext(reg_A - reg_B);
      OP_AND:   result_s = zext(reg_A & reg_B);
      OP_OR:    result_s = zext(reg_A | reg_B);
      OP_SHR:   result_s = zext(reg_A >> amt_s);
      OP_SHRA:  result_s = zext(sra_s);
      OP_SHL:   result_s = zext(reg_A << amt_s);
      OP_ROR:   result_s = zext(ror_full_s[WIDTH-1:0]);
      OP_ROL:   result_s = zext(rol_full_s[2*WIDTH-1:WIDTH]);
      OP_MUL:   result_s = prod_s;
`ifdef MINI_ALU_DIV_EN
      OP_DIV:   result_s = {rem_s, quo_s};
`else
      OP_DIV:   result_s = (2*WIDTH)'(RESULT_RESERVED);
`endif
      OP_NEG:   result_s = zext(-reg_A);
      OP_NOT:   result_s = zext(~reg_A);
      OP_PASSA: result_s = zext(reg_A);
      OP_PASSB: result_s = zext(reg_B);
      default:  result_s = (2*WIDTH)'(RESULT_RESERVED);
    endcase
  end

  // Result register; Clear low forces zero ahead of any operation
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      reg_C <= '0;
    end else begin
      reg_C <= result_s;
    end
  end

endmodule

// File: tb/tb_mini_alu.sv
// Self-checking bench for mini_alu: directed plan items followed by randomized
// back-to-back operations compared against an arithmetic reference model.
module tb_mini_alu;

  logic        Clock;
  logic        Clear;
  logic [4:0]  Control;
  logic [31:0] reg_A;
  logic [31:0] reg_B;
  logic [63:0] reg_C;

  int checks;
  int failures;

  mini_alu dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .Control (Control),
    .reg_A   (reg_A),
    .reg_B   (reg_B),
    .reg_C   (reg_C)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] mask;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] r;
    logic [63:0] qv;
    logic [63:0] rv;
    longint      sa;
    longint      sb;
    int unsigned n;
    mask = 64'h0000_0000_FFFF_FFFF;
    ua   = {32'h0, a};
    ub   = {32'h0, b};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    n    = int'(b[4:0]);
    qv   = 64'h0;
    rv   = 64'h0;
    case (op)
      5'd0:  r = (ua + ub) & mask;
      5'd1:  r = (ua - ub) & mask;
      5'd2:  r = ua & ub;
      5'd3:  r = ua | ub;
      5'd4:  r = ua >> n;
      5'd5:  r = 64'(sa >>> n) & mask;
      5'd6:  r = (ua << n) & mask;
      5'd7:  r = (n == 0) ? ua : (((ua >> n) | (ua << (32 - n))) & mask);
      5'd8:  r = (n == 0) ? ua : (((ua << n) | (ua >> (32 - n))) & mask);
      5'd9:  r = 64'(sa * sb);
`ifdef MINI_ALU_DIV_EN
      5'd10: begin
        if (b == 32'h0) begin
          r = {a, 32'hFFFF_FFFF};
        end else begin
          qv = 64'(sa / sb);
          rv = 64'(sa % sb);
          r  = {rv[31:0], qv[31:0]};
        end
      end
`else
      5'd10: r = 64'h0;
`endif
      5'd11: r = (64'h0 - ua) & mask;
      5'd12: r = ~ua & mask;
      5'd13: r = ua;
      5'd14: r = ub;
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare the value registered on that edge
  task automatic step(input string tag, input logic clr, input logic [4:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    Clear   = clr;
    Control = op;
    reg_A   = a;
    reg_B   = b;
    @(posedge Clock);
    #1;
    check(tag, reg_C, exp);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        clr;
    logic [63:0] exp;
    checks   = 0;
    failures = 0;
    Clear    = 1'b0;
    Control  = 5'd9;
    reg_A    = 32'h1234_5678;
    reg_B    = 32'h9ABC_DEF0;
    #2;

    step("reset", 1'b0, 5'd9, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0);
    step("add_4_4", 1'b1, 5'd0, 32'd4, 32'd4, 64'h0000_0000_0000_0008);
    step("sub_4_4", 1'b1, 5'd1, 32'd4, 32'd4, 64'h0);
    step("sub_3_5", 1'b1, 5'd1, 32'd3, 32'd5, 64'h0000_0000_FFFF_FFFE);
    step("add_carry", 1'b1, 5'd0, 32'hFFFF_FFFF, 32'd1, 64'h0);
    step("mul_neg3_5", 1'b1, 5'd9, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    step("mul_minsq", 1'b1, 5'd9, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
`ifdef MINI_ALU_DIV_EN
    step("div_7_m2", 1'b1, 5'd10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    step("div_9_0", 1'b1, 5'd10, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
    step("div_ovf", 1'b1, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    step("div_m7_2", 1'b1, 5'd10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    step("div_off", 1'b1, 5'd10, 32'd7, 32'hFFFF_FFFE, 64'h0);
    step("div_off_0", 1'b1, 5'd10, 32'd9, 32'd0, 64'h0);
`endif
    step("ror_1", 1'b1, 5'd7, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
    step("shra_1", 1'b1, 5'd5, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
    step("shr_1", 1'b1, 5'd4, 32'h8000_0001, 32'd1, 64'h0000_0000_4000_0000);
    step("rol_1", 1'b1, 5'd8, 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0003);
    step("shl_33", 1'b1, 5'd6, 32'd1, 32'h0000_0021, 64'h0000_0000_0000_0002);
    step("ror_0", 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0000_0020, 64'h0000_0000_DEAD_BEEF);
    step("neg_min", 1'b1, 5'd11, 32'h8000_0000, 32'd0, 64'h0000_0000_8000_0000);
    step("not", 1'b1, 5'd12, 32'h0F0F_0000, 32'd0, 64'h0000_0000_F0F0_FFFF);
    step("passb", 1'b1, 5'd14, 32'd1, 32'hCAFE_F00D, 64'h0000_0000_CAFE_F00D);
    step("reserved", 1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);
    step("clr_mid", 1'b0, 5'd13, 32'h5555_AAAA, 32'd0, 64'h0);
    step("resume", 1'b1, 5'd13, 32'h5555_AAAA, 32'd0, 64'h0000_0000_5555_AAAA);

    // Randomized back-to-back stream with occasional mid-stream Clear
    for (int i = 0; i < 400; i++) begin
      op  = 5'($urandom_range(0, 31));
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(0, 2)) - 32'd1;
      clr = ($urandom_range(0, 19) != 0);
      exp = clr ? model(op, a, b) : 64'h0;
      step("random", clr, op, a, b, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
